// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: per-stage enables/flushes, load-use stalls, redirect squash, FPU start/wait.
// Combinational control outputs; stall counter, timeout flag and FSM state update on the rising clock edge.
// Stalls the front end while a load-use hazard or a multi-cycle FP op is pending; aborts the FP op after TIMEOUT_CYCLES.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       in_id_rs1,
    input  logic [4:0]       in_id_rs2,
    input  logic [1:0]       in_id_rd_int,
    input  logic [1:0]       in_id_rd_fp,
    input  logic [4:0]       in_ex_rd,
    input  logic             in_ex_load_int,
    input  logic             in_ex_load_fp,
    input  logic             in_ex_fpu_multi,
    input  logic             in_ex_redirect,
    input  logic             in_fpu_done,
    output logic             out_pc_en,
    output logic             out_if_id_en,
    output logic             out_id_ex_en,
    output logic             out_if_id_flush,
    output logic             out_id_ex_flush,
    output logic             out_ex_mem_bubble,
    output logic             out_fpu_start,
    output logic             out_timeout_err,
    output logic [CNT_W-1:0] out_stall_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        RUN,
        FPU_WAIT
    } state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic int_hit;
    logic fp_hit;
    logic lu;

    // x0 is hardwired zero in the integer RF only; f0 is a real register.
    assign int_hit = in_ex_load_int && (in_ex_rd != 5'd0) &&
                     ((in_id_rd_int[0] && (in_id_rs1 == in_ex_rd)) ||
                      (in_id_rd_int[1] && (in_id_rs2 == in_ex_rd)));
    assign fp_hit  = in_ex_load_fp &&
                     ((in_id_rd_fp[0] && (in_id_rs1 == in_ex_rd)) ||
                      (in_id_rd_fp[1] && (in_id_rs2 == in_ex_rd)));
    assign lu      = int_hit || fp_hit;

    always_comb begin
        out_pc_en         = 1'b1;
        out_if_id_en      = 1'b1;
        out_id_ex_en      = 1'b1;
        out_if_id_flush   = 1'b0;
        out_id_ex_flush   = 1'b0;
        out_ex_mem_bubble = 1'b0;
        out_fpu_start     = 1'b0;
        state_d           = state_q;
        tcnt_d            = tcnt_q;
        err_d             = err_q;

        if (!Rst) begin
            case (state_q)
                RUN: begin
                    if (in_ex_fpu_multi) begin
                        out_fpu_start     = 1'b1;
                        out_pc_en         = 1'b0;
                        out_if_id_en      = 1'b0;
                        out_id_ex_en      = 1'b0;
                        out_ex_mem_bubble = 1'b1;
                        state_d           = FPU_WAIT;
                        tcnt_d            = '0;
                    end else if (in_ex_redirect) begin
                        // ID holds a wrong-path instruction, so any hazard it sees is moot.
                        out_if_id_flush = 1'b1;
                        out_id_ex_flush = 1'b1;
                    end else if (lu) begin
                        out_pc_en       = 1'b0;
                        out_if_id_en    = 1'b0;
                        out_id_ex_flush = 1'b1;
                    end
                end
                FPU_WAIT: begin
                    if (in_fpu_done) begin
                        state_d = RUN;
                    end else if (tcnt_q == TCNT_LAST) begin
                        // Release the pipe but drop the hung op's result.
                        out_ex_mem_bubble = 1'b1;
                        err_d             = 1'b1;
                        state_d           = RUN;
                    end else begin
                        out_pc_en         = 1'b0;
                        out_if_id_en      = 1'b0;
                        out_id_ex_en      = 1'b0;
                        out_ex_mem_bubble = 1'b1;
                        tcnt_d            = tcnt_q + TW'(1);
                    end
                end
                default: state_d = RUN;
            endcase
        end

        cnt_d = cnt_q;
        if (!out_pc_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= RUN;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_timeout_err = err_q;
    assign out_stall_cnt   = cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, hand-written multi-cycle sequences, and random stimulus against a reference model.
module tb_pipe_hazard_ctrl;
    localparam int T_SMALL = 4;
    localparam int W_SMALL = 4;

    // {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, ex_mem_bubble, fpu_start}
    localparam logic [6:0] NORM  = 7'b111_00_0_0;
    localparam logic [6:0] LU    = 7'b001_01_0_0;
    localparam logic [6:0] RDR   = 7'b111_11_0_0;
    localparam logic [6:0] START = 7'b000_00_1_1;
    localparam logic [6:0] WAIT  = 7'b000_00_1_0;
    localparam logic [6:0] TO    = 7'b111_00_1_0;

    logic Clk = 1'b0;
    logic Rst;
    logic [4:0] rs1, rs2, ex_rd;
    logic [1:0] rd_int, rd_fp;
    logic ld_int, ld_fp, multi, redir, done;

    logic s_pc, s_ifid, s_idex, s_iff, s_idf, s_bub, s_st, s_err;
    logic [W_SMALL-1:0] s_cnt;
    logic b_pc, b_ifid, b_idex, b_iff, b_idf, b_bub, b_st, b_err;
    logic [31:0] b_cnt;
    logic [6:0] s_vec, b_vec;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clk = ~Clk;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(T_SMALL), .CNT_W(W_SMALL)) dut (
        .Clk(Clk), .Rst(Rst),
        .in_id_rs1(rs1), .in_id_rs2(rs2), .in_id_rd_int(rd_int), .in_id_rd_fp(rd_fp),
        .in_ex_rd(ex_rd), .in_ex_load_int(ld_int), .in_ex_load_fp(ld_fp),
        .in_ex_fpu_multi(multi), .in_ex_redirect(redir), .in_fpu_done(done),
        .out_pc_en(s_pc), .out_if_id_en(s_ifid), .out_id_ex_en(s_idex),
        .out_if_id_flush(s_iff), .out_id_ex_flush(s_idf), .out_ex_mem_bubble(s_bub),
        .out_fpu_start(s_st), .out_timeout_err(s_err), .out_stall_cnt(s_cnt)
    );

    pipe_hazard_ctrl dut_big (
        .Clk(Clk), .Rst(Rst),
        .in_id_rs1(rs1), .in_id_rs2(rs2), .in_id_rd_int(rd_int), .in_id_rd_fp(rd_fp),
        .in_ex_rd(ex_rd), .in_ex_load_int(ld_int), .in_ex_load_fp(ld_fp),
        .in_ex_fpu_multi(multi), .in_ex_redirect(redir), .in_fpu_done(done),
        .out_pc_en(b_pc), .out_if_id_en(b_ifid), .out_id_ex_en(b_idex),
        .out_if_id_flush(b_iff), .out_id_ex_flush(b_idf), .out_ex_mem_bubble(b_bub),
        .out_fpu_start(b_st), .out_timeout_err(b_err), .out_stall_cnt(b_cnt)
    );

    assign s_vec = {s_pc, s_ifid, s_idex, s_iff, s_idf, s_bub, s_st};
    assign b_vec = {b_pc, b_ifid, b_idex, b_iff, b_idf, b_bub, b_st};

    typedef struct {
        logic       rst;
        logic [4:0] rs1, rs2;
        logic [1:0] rd_int, rd_fp;
        logic [4:0] ex_rd;
        logic       ld_int, ld_fp, multi, redir, done;
        logic [6:0] exp;
        logic       err;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                                input logic [1:0] fi, input logic [1:0] ff, input logic [4:0] rd,
                                input logic li, input logic lf, input logic m, input logic rr,
                                input logic d, input logic [6:0] e, input logic er, input logic [3:0] c);
        vec_t v;
        v.rst = r; v.rs1 = a1; v.rs2 = a2; v.rd_int = fi; v.rd_fp = ff; v.ex_rd = rd;
        v.ld_int = li; v.ld_fp = lf; v.multi = m; v.redir = rr; v.done = d;
        v.exp = e; v.err = er; v.cnt = c;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        Rst = v.rst; rs1 = v.rs1; rs2 = v.rs2; rd_int = v.rd_int; rd_fp = v.rd_fp;
        ex_rd = v.ex_rd; ld_int = v.ld_int; ld_fp = v.ld_fp; multi = v.multi;
        redir = v.redir; done = v.done;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    vec_t idle, lw5, rst_v;

    // Reference model state
    bit m_wait;
    int m_waited;
    bit m_err;
    int m_cnt;

    function automatic bit model_lu(input vec_t v);
        bit hit = 0;
        for (int s = 0; s < 2; s++) begin
            logic [4:0] a = (s == 0) ? v.rs1 : v.rs2;
            if (v.ld_int && v.ex_rd != 0 && v.rd_int[s] && a == v.ex_rd) hit = 1;
            if (v.ld_fp && v.rd_fp[s] && a == v.ex_rd) hit = 1;
        end
        return hit;
    endfunction

    function automatic logic [6:0] model_out(input vec_t v);
        if (v.rst) return NORM;
        if (!m_wait) begin
            if (v.multi) return START;
            if (v.redir) return RDR;
            if (model_lu(v)) return LU;
            return NORM;
        end
        if (v.done) return NORM;
        if (m_waited == T_SMALL - 1) return TO;
        return WAIT;
    endfunction

    task automatic model_step(input vec_t v, input logic [6:0] e);
        if (v.rst) begin
            m_wait = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (!e[6] && m_cnt < (1 << W_SMALL) - 1) m_cnt++;
            if (!m_wait) begin
                if (v.multi) begin m_wait = 1; m_waited = 0; end
            end else if (v.done) begin
                m_wait = 0;
            end else if (m_waited == T_SMALL - 1) begin
                m_err = 1; m_wait = 0;
            end else begin
                m_waited++;
            end
        end
    endtask

    initial begin
        idle  = mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM, 0, 0);
        lw5   = mk(0, 5, 0, 2'b01, 2'b00, 5, 1, 0, 0, 0, 0, LU, 0, 0);
        rst_v = idle; rst_v.rst = 1;

        vecs.push_back(mk(1, 5, 0, 2'b01, 2'b00, 5, 1, 0, 0, 0, 0, NORM,  0, 0));
        vecs.push_back(mk(0, 5, 0, 2'b01, 2'b00, 5, 1, 0, 0, 0, 0, LU,    0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM,  0, 1));
        vecs.push_back(mk(0, 0, 0, 2'b01, 2'b00, 0, 1, 0, 0, 0, 0, NORM,  0, 1));
        vecs.push_back(mk(0, 7, 3, 2'b10, 2'b00, 7, 1, 0, 0, 0, 0, NORM,  0, 1));
        vecs.push_back(mk(0, 4, 0, 2'b01, 2'b00, 4, 0, 1, 0, 0, 0, NORM,  0, 1));
        vecs.push_back(mk(0, 3, 0, 2'b00, 2'b10, 0, 0, 1, 0, 0, 0, LU,    0, 1));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM,  0, 2));
        vecs.push_back(mk(0, 5, 0, 2'b01, 2'b00, 5, 1, 0, 0, 1, 0, RDR,   0, 2));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM,  0, 2));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, START, 0, 2));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, WAIT,  0, 3));
        vecs.push_back(mk(0, 5, 0, 2'b01, 2'b00, 5, 1, 0, 1, 1, 0, WAIT,  0, 4));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, WAIT,  0, 5));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, NORM,  0, 6));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM,  0, 6));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, START, 0, 6));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, WAIT,  0, 7));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, WAIT,  0, 8));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, WAIT,  0, 9));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, TO,    0, 10));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM,  1, 10));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, START, 1, 10));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, WAIT,  1, 11));
        vecs.push_back(mk(1, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, NORM,  1, 12));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, NORM,  0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0, 0, START, 0, 0));
        vecs.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 1, NORM,  0, 1));

        drive(rst_v);
        tick(); tick();

        // Directed table
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge Clk);
            check($sformatf("vec%0d ctrl", i), 64'(s_vec), 64'(vecs[i].exp));
            check($sformatf("vec%0d err", i), 64'(s_err), 64'(vecs[i].err));
            check($sformatf("vec%0d cnt", i), 64'(s_cnt), 64'(vecs[i].cnt));
            tick();
        end

        // Stall counter saturation: 20 load-use cycles on a 4-bit counter
        drive(rst_v); tick();
        drive(lw5);
        for (int k = 0; k < 20; k++) tick();
        @(negedge Clk);
        check("sat ctrl", 64'(s_vec), 64'(LU));
        check("sat cnt", 64'(s_cnt), 64'd15);

        // Long FP op on the default-parameter instance: start, 10 wait cycles, done
        drive(rst_v); tick();
        drive(idle); multi = 1;
        @(negedge Clk);
        check("big start", 64'(b_vec), 64'(START));
        tick();
        multi = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            check($sformatf("big wait%0d", k), 64'(b_vec), 64'(WAIT));
            tick();
        end
        done = 1;
        @(negedge Clk);
        check("big release", 64'(b_vec), 64'(NORM));
        tick();
        done = 0;
        @(negedge Clk);
        check("big after", 64'(b_vec), 64'(NORM));
        check("big cnt", 64'(b_cnt), 64'd11);
        check("big err", 64'(b_err), 64'd0);

        // Random stimulus against the model
        drive(rst_v); tick();
        m_wait = 0; m_waited = 0; m_err = 0; m_cnt = 0;
        for (int k = 0; k < 600; k++) begin
            vec_t v;
            logic [6:0] e;
            v.rst    = ($urandom_range(0, 29) == 0);
            v.rs1    = 5'($urandom_range(0, 3));
            v.rs2    = 5'($urandom_range(0, 3));
            v.rd_int = 2'($urandom);
            v.rd_fp  = 2'($urandom);
            v.ex_rd  = 5'($urandom_range(0, 3));
            v.ld_int = ($urandom_range(0, 2) == 0);
            v.ld_fp  = ($urandom_range(0, 2) == 0);
            v.multi  = ($urandom_range(0, 7) == 0);
            v.redir  = ($urandom_range(0, 5) == 0);
            v.done   = ($urandom_range(0, 3) == 0);
            drive(v);
            e = model_out(v);
            @(negedge Clk);
            check($sformatf("rnd%0d ctrl", k), 64'(s_vec), 64'(e));
            check($sformatf("rnd%0d err", k), 64'(s_err), 64'(m_err));
            check($sformatf("rnd%0d cnt", k), 64'(s_cnt), 64'(m_cnt));
            tick();
            model_step(v, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
